// File: rtl/zx_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zx_video_pkg
// Purpose  : Shared colour types and conversions for the ZX pixel output path.
// Revision : 1.0 - initial release
// ============================================================================
package zx_video_pkg;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb9_t;

    localparam logic [2:0] LVL_NORM   = 3'd5;
    localparam logic [2:0] LVL_BRIGHT = 3'd7;

    // Blue has only two bits in GRB332; the OR fills its LSB so full blue reaches 7.
    function automatic rgb9_t grb332_to_rgb9(input logic [7:0] grb);
        rgb9_t c;
        c.g = grb[7:5];
        c.r = grb[4:2];
        c.b = {grb[1:0], grb[1] | grb[0]};
        return c;
    endfunction

    function automatic rgb9_t classic_rgb(input logic [3:0] idx);
        rgb9_t      c;
        logic [2:0] lvl;
        lvl = idx[3] ? LVL_BRIGHT : LVL_NORM;
        c.b = idx[0] ? lvl : 3'd0;
        c.r = idx[1] ? lvl : 3'd0;
        c.g = idx[2] ? lvl : 3'd0;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ulaplus_pixel_out.sv
`default_nettype none
// ============================================================================
// Module   : ulaplus_pixel_out
// Purpose  : Serialises bitmap/attribute bytes and maps pixels to 9-bit RGB
//            through the ULAplus palette or the classic 15-colour palette.
// Revision : 1.0 - initial release
// ============================================================================
module ulaplus_pixel_out
    import zx_video_pkg::*;
#(
    parameter int PAL_LAT = 3
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic       ck7,
    input  logic       load,
    input  logic [7:0] bitmap,
    input  logic [7:0] attr,
    input  logic       border,
    input  logic [2:0] border_col,
    input  logic       blank,
    input  logic       flash,
    input  logic       plus_en,
    output logic [5:0] ink_addr,
    output logic [5:0] paper_addr,
    input  logic [7:0] ink,
    input  logic [7:0] paper,
    output logic [2:0] r,
    output logic [2:0] g,
    output logic [2:0] b
);

    // The palette must answer within one pixel period (4 clk28).
    if (PAL_LAT > 3) begin : g_pal_lat_bad
        $error("ulaplus_pixel_out: PAL_LAT must be <= 3");
    end

    logic [7:0] shift_q, shift_d;
    logic [7:0] attr_q, attr_d;
    logic       pix_s0_q, border_s0_q, blank_s0_q, mode_s0_q, flash_s0_q;
    logic [7:0] attr_s0_q;
    logic [2:0] bcol_s0_q;
    logic [5:0] ink_addr_q, ink_addr_d;
    logic [5:0] paper_addr_q, paper_addr_d;
    rgb9_t      rgb_q, rgb_d;
    logic [3:0] idx;

    always_comb begin
        shift_d      = load ? bitmap : {shift_q[6:0], 1'b0};
        attr_d       = load ? attr : attr_q;
        ink_addr_d   = ink_addr_q;
        paper_addr_d = paper_addr_q;
        if (plus_en && border) begin
            paper_addr_d = {3'b001, border_col};
        end else begin
            ink_addr_d   = {attr_q[7:6], 1'b0, attr_q[2:0]};
            paper_addr_d = {attr_q[7:6], 1'b1, attr_q[5:3]};
        end

        if (border_s0_q)
            idx = {1'b0, bcol_s0_q};
        else if (pix_s0_q ^ (flash_s0_q & attr_s0_q[7]))
            idx = {attr_s0_q[6], attr_s0_q[2:0]};
        else
            idx = {attr_s0_q[6], attr_s0_q[5:3]};

        if (blank_s0_q)
            rgb_d = '0;
        else if (mode_s0_q)
            rgb_d = grb332_to_rgb9((pix_s0_q && !border_s0_q) ? ink : paper);
        else
            rgb_d = classic_rgb(idx);
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            shift_q      <= '0;
            attr_q       <= '0;
            pix_s0_q     <= 1'b0;
            border_s0_q  <= 1'b0;
            blank_s0_q   <= 1'b0;
            mode_s0_q    <= 1'b0;
            flash_s0_q   <= 1'b0;
            attr_s0_q    <= '0;
            bcol_s0_q    <= '0;
            ink_addr_q   <= '0;
            paper_addr_q <= '0;
            rgb_q        <= '0;
        end else if (ck7) begin
            shift_q      <= shift_d;
            attr_q       <= attr_d;
            // s0 captures the pixel leaving the shifter with the context it belongs to
            pix_s0_q     <= shift_q[7];
            border_s0_q  <= border;
            blank_s0_q   <= blank;
            mode_s0_q    <= plus_en;
            flash_s0_q   <= flash;
            attr_s0_q    <= attr_q;
            bcol_s0_q    <= border_col;
            ink_addr_q   <= ink_addr_d;
            paper_addr_q <= paper_addr_d;
            rgb_q        <= rgb_d;
        end
    end

    assign ink_addr   = ink_addr_q;
    assign paper_addr = paper_addr_q;
    assign r          = rgb_q.r;
    assign g          = rgb_q.g;
    assign b          = rgb_q.b;

endmodule
`default_nettype wire

// File: tb/tb_ulaplus_pixel_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_ulaplus_pixel_out
// Purpose  : Self-checking bench with a pixel-level reference model and palette.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ulaplus_pixel_out;

    localparam int c_pal_lat = 3;

    logic       clk28 = 1'b0;
    logic       rst, ck7, load, border, blank, flash, plus_en;
    logic [7:0] bitmap, attr;
    logic [2:0] border_col;
    logic [5:0] ink_addr, paper_addr;
    logic [7:0] ink, paper;
    logic [2:0] r, g, b;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [7:0] pal [64];
    logic [7:0] ink_p1, ink_p2, paper_p1, paper_p2;

    always #5 clk28 = ~clk28;

    ulaplus_pixel_out #(.PAL_LAT(c_pal_lat)) dut (
        .clk28(clk28), .rst(rst), .ck7(ck7), .load(load), .bitmap(bitmap),
        .attr(attr), .border(border), .border_col(border_col), .blank(blank),
        .flash(flash), .plus_en(plus_en), .ink_addr(ink_addr),
        .paper_addr(paper_addr), .ink(ink), .paper(paper), .r(r), .g(g), .b(b)
    );

    // Palette RAM stand-in: data follows an address change after c_pal_lat cycles.
    always @(posedge clk28) begin
        ink_p1   <= pal[ink_addr];
        ink_p2   <= ink_p1;
        ink      <= ink_p2;
        paper_p1 <= pal[paper_addr];
        paper_p2 <= paper_p1;
        paper    <= paper_p2;
    end

    function automatic logic [8:0] model_rgb(input logic bl, input logic plus,
                                             input logic px, input logic brd,
                                             input logic fl, input logic [7:0] at,
                                             input logic [2:0] bc,
                                             input logic [7:0] ink_v,
                                             input logic [7:0] paper_v);
        logic [7:0] sel;
        int         colour, level;
        logic [2:0] rr, gg, bb;
        if (bl) return 9'd0;
        if (plus) begin
            sel = (px && !brd) ? ink_v : paper_v;
            return {sel[4:2], sel[7:5], sel[1:0], sel[1] | sel[0]};
        end
        if (brd) begin
            colour = int'(bc);
            level  = 5;
        end else begin
            colour = (px ^ (fl & at[7])) ? int'(at) % 8 : (int'(at) / 8) % 8;
            level  = at[6] ? 7 : 5;
        end
        rr = (colour & 2) != 0 ? 3'(level) : 3'd0;
        gg = (colour & 4) != 0 ? 3'(level) : 3'd0;
        bb = (colour & 1) != 0 ? 3'(level) : 3'd0;
        return {rr, gg, bb};
    endfunction

    // Reference model: the current byte plus a count of pixels already emitted.
    logic [7:0] m_byte, m_attr, p_attr;
    int         m_k, since_ck7;
    logic       p_pix, p_brd, p_blank, p_mode, p_flash;
    logic [2:0] p_bcol;
    logic [5:0] e_ink, e_paper;
    logic [8:0] e_rgb;

    initial begin
        since_ck7 = 100;
        forever begin
            @(posedge clk28);
            if (ck7) begin
                n_checks++;
                if (since_ck7 < c_pal_lat + 1) begin
                    n_fail++;
                    $display("FAIL ck7_spacing: gap %0d cycles, required >= %0d", since_ck7, c_pal_lat + 1);
                end
                since_ck7 = 1;
            end else begin
                since_ck7++;
            end
            if (rst) begin
                m_byte = 8'd0; m_attr = 8'd0; m_k = 8;
                p_pix = 0; p_brd = 0; p_blank = 0; p_mode = 0; p_flash = 0;
                p_attr = 8'd0; p_bcol = 3'd0;
                e_ink = 6'd0; e_paper = 6'd0; e_rgb = 9'd0;
            end else if (ck7) begin
                e_rgb = model_rgb(p_blank, p_mode, p_pix, p_brd, p_flash, p_attr,
                                  p_bcol, pal[e_ink], pal[e_paper]);
                p_pix   = (m_k < 8) ? m_byte[7 - m_k] : 1'b0;
                p_brd   = border;
                p_blank = blank;
                p_mode  = plus_en;
                p_flash = flash;
                p_attr  = m_attr;
                p_bcol  = border_col;
                if (plus_en && border) begin
                    e_paper = {3'b001, border_col};
                end else begin
                    e_ink   = {m_attr[7:6], 1'b0, m_attr[2:0]};
                    e_paper = {m_attr[7:6], 1'b1, m_attr[5:3]};
                end
                if (load) begin
                    m_byte = bitmap;
                    m_attr = attr;
                    m_k    = 0;
                end else if (m_k < 8) begin
                    m_k++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk28);
            if (chk_en) begin
                n_checks++;
                if ({r, g, b} !== e_rgb || ink_addr !== e_ink || paper_addr !== e_paper) begin
                    n_fail++;
                    $display("FAIL model_cmp t=%0t: rgb=%o ink_addr=%0d paper_addr=%0d, expected rgb=%o ink_addr=%0d paper_addr=%0d",
                             $time, {r, g, b}, ink_addr, paper_addr, e_rgb, e_ink, e_paper);
                end
            end
        end
    end

    task automatic check_val(input string nm, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %o, expected %o", nm, got, exp);
        end
    endtask

    task automatic tick7(input logic ld, input logic [7:0] bm, input logic [7:0] at);
        repeat (2) @(negedge clk28);
        @(negedge clk28);
        ck7 = 1'b1; load = ld; bitmap = bm; attr = at;
        @(negedge clk28);
        ck7 = 1'b0; load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ck7 = 1'b0; load = 1'b0; bitmap = 8'd0; attr = 8'd0;
        border = 1'b0; border_col = 3'd0; blank = 1'b0; flash = 1'b0; plus_en = 1'b0;
        for (int i = 0; i < 64; i++) pal[i] = 8'($urandom);
        pal[5] = 8'hE3; pal[12] = 8'h1C; pal[11] = 8'h03; pal[23] = 8'h1C;

        repeat (2) @(negedge clk28);
        chk_en = 1'b1;
        check_val("reset_rgb", {r, g, b}, 9'o000);
        check_val("reset_ink_addr", {3'd0, ink_addr}, 9'd0);
        check_val("reset_paper_addr", {3'd0, paper_addr}, 9'd0);
        rst = 1'b0;
        tick7(1'b0, 8'h00, 8'h00);
        check_val("first_tick_black", {r, g, b}, 9'o000);

        // Classic: bright white ink pixel then bright blue paper.
        tick7(1'b1, 8'h80, 8'h4F);
        tick7(1'b0, 8'h00, 8'h00);
        tick7(1'b0, 8'h00, 8'h00);
        check_val("classic_ink", {r, g, b}, 9'o777);
        for (int i = 0; i < 7; i++) begin
            tick7(1'b0, 8'h00, 8'h00);
            check_val("classic_paper", {r, g, b}, 9'o007);
        end

        // Classic flash swaps ink and paper.
        flash = 1'b1;
        tick7(1'b1, 8'h80, 8'hCF);
        tick7(1'b0, 8'h00, 8'h00);
        tick7(1'b0, 8'h00, 8'h00);
        check_val("flash_first", {r, g, b}, 9'o007);
        for (int i = 0; i < 7; i++) begin
            tick7(1'b0, 8'h00, 8'h00);
            check_val("flash_rest", {r, g, b}, 9'o777);
        end
        flash = 1'b0;

        // ULAplus ink/paper from the palette.
        plus_en = 1'b1;
        tick7(1'b1, 8'hF0, 8'h25);
        tick7(1'b0, 8'h00, 8'h00);
        check_val("plus_ink_addr", {3'd0, ink_addr}, 9'd5);
        check_val("plus_paper_addr", {3'd0, paper_addr}, 9'd12);
        for (int i = 0; i < 8; i++) begin
            tick7(1'b0, 8'h00, 8'h00);
            check_val(i < 4 ? "plus_ink_px" : "plus_paper_px", {r, g, b},
                      i < 4 ? 9'o077 : 9'o700);
        end

        // ULAplus border.
        border = 1'b1; border_col = 3'd3;
        tick7(1'b0, 8'h00, 8'h00);
        check_val("plus_border_addr", {3'd0, paper_addr}, 9'd11);
        tick7(1'b0, 8'h00, 8'h00);
        check_val("plus_border_rgb", {r, g, b}, 9'o007);
        border = 1'b0;

        // Mode switch follows its pixel; blanking forces black.
        plus_en = 1'b0;
        tick7(1'b1, 8'hFF, 8'h4F);
        tick7(1'b0, 8'h00, 8'h00);
        plus_en = 1'b1;
        tick7(1'b0, 8'h00, 8'h00);
        check_val("toggle_still_classic", {r, g, b}, 9'o777);
        tick7(1'b0, 8'h00, 8'h00);
        check_val("toggle_now_plus", {r, g, b}, 9'o700);
        blank = 1'b1;
        tick7(1'b0, 8'h00, 8'h00);
        blank = 1'b0;
        tick7(1'b0, 8'h00, 8'h00);
        check_val("blank_black", {r, g, b}, 9'o000);
        plus_en = 1'b0;

        // Randomised traffic, with one reset in the middle of a line.
        for (int i = 0; i < 800; i++) begin
            if (i == 403) begin
                @(negedge clk28);
                rst = 1'b1;
                repeat (2) @(negedge clk28);
                rst = 1'b0;
                tick7(1'b1, 8'($urandom), 8'($urandom));
                check_val("midline_reset_black", {r, g, b}, 9'o000);
            end
            border     = ($urandom_range(0, 7) == 0);
            border_col = 3'($urandom);
            blank      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) plus_en = ~plus_en;
            if ($urandom_range(0, 19) == 0) flash = ~flash;
            tick7((i % 8 == 0) || ($urandom_range(0, 15) == 0), 8'($urandom), 8'($urandom));
        end

        repeat (8) @(negedge clk28);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
